// File: rtl/nios_debug_arb_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory arbiter.
package nios_debug_arb_pkg;

  localparam int unsigned JDO_W             = 38;
  localparam int unsigned JDO_RD_AFTER_LOAD = 35;
  localparam int unsigned JDO_WDATA_LSB     = 3;
  localparam int unsigned JDO_ADDR_LSB      = 2;
  localparam int unsigned BE_W              = 4;

  typedef enum logic [1:0] {IDLE, JT_RD, AV_RD} arb_state_e;
  typedef enum logic [1:0] {NONE, RD, WR}       pend_op_e;
  typedef enum logic       {JT, AV}             grant_e;

endpackage

// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG debug commands and the
// CPU's Avalon debug_mem slave using round-robin arbitration.
// Optional write protection of the upper Avalon region: define
// NIOS_DBG_OCIMEM_WRPROT_EN (adds PROT_BASE parameter and av_wp_err port).
// RAM command and Avalon handshake outputs are decoded from registered state
// so that an Avalon write completes in its grant cycle and a read in two.
module nios_debug_ocimem_arbiter
  import nios_debug_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
  , parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hC0)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  input  logic [BE_W-1:0]   av_byteenable,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] mon_addr,
  output logic              monitor_ready,
  output logic              jtag_overrun
`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
  , output logic            av_wp_err
`endif
);

  arb_state_e        state_q;
  pend_op_e          pend_q;
  grant_e            last_q;
  logic [DATA_W-1:0] wdata_q;

  logic jt_req, av_req, grant_jt, grant_av;
  logic jt_wr_go, jt_rd_go, av_rd_go, av_wr_go;
  logic slot_free, any_strobe, multi_strobe, wp_hit;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_AFTER_LOAD+1], jdo[JDO_ADDR_LSB-1:0]};

`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
  assign wp_hit = (av_address >= PROT_BASE);
`else
  assign wp_hit = 1'b0;
`endif

  assign monitor_ready = (pend_q == NONE) && (state_q != JT_RD);

  // Round-robin grant in IDLE plus JTAG strobe acceptance
  always_comb begin
    jt_req   = (pend_q != NONE);
    av_req   = av_read | av_write;
    grant_jt = 1'b0;
    grant_av = 1'b0;
    if (!reset && state_q == IDLE) begin
      grant_jt = jt_req & (~av_req | (last_q == AV));
      grant_av = av_req & ~grant_jt;
    end
    jt_wr_go     = grant_jt & (pend_q == WR);
    jt_rd_go     = grant_jt & (pend_q == RD);
    av_rd_go     = grant_av & av_read;
    av_wr_go     = grant_av & ~av_read;
    // the slot frees in the cycle its op completes, so a strobe there is kept
    slot_free    = (pend_q == NONE) | jt_wr_go | (state_q == JT_RD);
    any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                   (take_action_ocimem_a & take_no_action_ocimem_a) |
                   (take_action_ocimem_b & take_no_action_ocimem_a);
  end

  // RAM port and Avalon handshake decode; quiet while reset is asserted
  always_comb begin
    ram_addr       = '0;
    ram_wren       = 1'b0;
    ram_byteenable = '0;
    ram_wdata      = '0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;
    if (!reset) begin
      if (jt_wr_go || jt_rd_go) ram_addr = mon_addr;
      if (av_wr_go || av_rd_go) ram_addr = av_address;
      if (jt_wr_go) begin
        ram_wren       = 1'b1;
        ram_byteenable = {BE_W{1'b1}};
        ram_wdata      = wdata_q;
      end
      if (av_wr_go) begin
        ram_wren       = ~wp_hit;
        ram_byteenable = av_byteenable;
        ram_wdata      = av_writedata;
        av_waitrequest = 1'b0;
      end
      if (state_q == AV_RD) begin
        av_readdata    = ram_rdata;
        av_waitrequest = 1'b0;
      end
    end
  end

  // State, pending slot, JTAG pointer/data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= NONE;
      last_q       <= AV;
      wdata_q      <= '0;
      MonDReg      <= '0;
      mon_addr     <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jt_rd_go)      state_q <= JT_RD;
          else if (av_rd_go) state_q <= AV_RD;
        end
        default: state_q <= IDLE;
      endcase

      if (grant_jt)      last_q <= JT;
      else if (grant_av) last_q <= AV;

      if (jt_wr_go) begin
        mon_addr <= mon_addr + ADDR_W'(1);
        pend_q   <= NONE;
      end
      if (state_q == JT_RD) begin
        MonDReg  <= ram_rdata;
        mon_addr <= mon_addr + ADDR_W'(1);
        pend_q   <= NONE;
      end

      // newly accepted strobe overrides the completing op's updates
      if (slot_free) begin
        if (take_action_ocimem_a) begin
          mon_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
          pend_q   <= jdo[JDO_RD_AFTER_LOAD] ? RD : NONE;
        end else if (take_action_ocimem_b) begin
          pend_q  <= WR;
          wdata_q <= jdo[JDO_WDATA_LSB +: DATA_W];
        end else if (take_no_action_ocimem_a) begin
          pend_q <= RD;
        end
      end

      if (multi_strobe || (any_strobe && !slot_free)) jtag_overrun <= 1'b1;
    end
  end

`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
  // Sticky flag for Avalon writes swallowed by the protected region
  always_ff @(posedge clk) begin
    if (reset)                   av_wp_err <= 1'b0;
    else if (av_wr_go && wp_hit) av_wp_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Scoreboard bench for nios_debug_ocimem_arbiter: expected RAM writes and
// Avalon read data are queued at stimulus time and popped by a monitor.
module tb_nios_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic [7:0]  mon_addr;
  logic        monitor_ready;
  logic        jtag_overrun;
`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
  logic        av_wp_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [43:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem [256];

  nios_debug_ocimem_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_waitrequest          (av_waitrequest),
    .av_readdata             (av_readdata),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteenable          (ram_byteenable),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .mon_addr                (mon_addr),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
    , .av_wp_err             (av_wp_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read data one cycle after the address
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteenable[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every completed Avalon read must be expected
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wren) begin
        if (wr_q.size() == 0) chk("ram_wr_unexpected", 64'({ram_addr, ram_wdata, ram_byteenable}), 64'(0));
        else chk("ram_wr", 64'({ram_addr, ram_wdata, ram_byteenable}), 64'(wr_q.pop_front()));
      end
      if (av_read && !av_waitrequest) begin
        if (rd_q.size() == 0) chk("av_rd_unexpected", 64'(av_readdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("av_rdata", 64'(av_readdata), 64'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] r;
    r = '0;
    r[9:2] = a;
    r[35] = rd;
    return r;
  endfunction

  function automatic logic [37:0] jdo_wr(input logic [31:0] d);
    logic [37:0] r;
    r = '0;
    r[34:3] = d;
    return r;
  endfunction

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic to_ram);
    av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
    if (to_ram) wr_q.push_back({a, d, be});
    #1;
    chk("av_wr_ack", 64'(av_waitrequest), 64'(0));
    tick();
    av_write = 1'b0; av_byteenable = '0;
  endtask

  task automatic av_rd(input logic [7:0] a, input logic [31:0] exp);
    av_address = a; av_read = 1'b1;
    rd_q.push_back(exp);
    tick();
    tick();
    av_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0; av_byteenable = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(monitor_ready), 64'(1));
    chk("rst_waitreq", 64'(av_waitrequest), 64'(1));
    chk("rst_wren", 64'(ram_wren), 64'(0));
    chk("rst_mondreg", 64'(MonDReg), 64'(0));
    chk("rst_monaddr", 64'(mon_addr), 64'(0));
    chk("rst_overrun", 64'(jtag_overrun), 64'(0));
    chk("rst_rdata", 64'(av_readdata), 64'(0));
    chk("rst_ramaddr", 64'(ram_addr), 64'(0));

    // JTAG address load then write DEADBEEF to 0x10
    jdo = jdo_addr(8'h10, 1'b0); take_a = 1; tick(); take_a = 0;
    chk("t1_monaddr_load", 64'(mon_addr), 64'(8'h10));
    jdo = jdo_wr(32'hDEADBEEF); take_b = 1;
    wr_q.push_back({8'h10, 32'hDEADBEEF, 4'hF});
    tick(); take_b = 0;
    chk("t1_busy", 64'(monitor_ready), 64'(0));
    tick();
    chk("t1_monaddr_inc", 64'(mon_addr), 64'(8'h11));
    chk("t1_ready", 64'(monitor_ready), 64'(1));

    // JTAG load with read-after-load of 0x10
    jdo = jdo_addr(8'h10, 1'b1); take_a = 1; tick(); take_a = 0; #1;
    chk("t2_ramaddr", 64'(ram_addr), 64'(8'h10));
    tick();
    chk("t2_busy_jtrd", 64'(monitor_ready), 64'(0));
    tick();
    chk("t2_mondreg", 64'(MonDReg), 64'(32'hDEADBEEF));
    chk("t2_monaddr", 64'(mon_addr), 64'(8'h11));
    chk("t2_ready", 64'(monitor_ready), 64'(1));

    // Avalon partial write then read-back: bytes 0 and 2 replaced
    av_wr(8'h20, 32'h12345678, 4'b0101, 1'b1);
    av_rd(8'h20, 32'h10340078);

    // Round-robin: JTAG wins first tie after reset, the next tie goes to Avalon
    reset = 1; tick(); reset = 0;
    take_na = 1; tick(); take_na = 0;                    // cycle 1
    av_address = 8'h10; av_read = 1; rd_q.push_back(32'hDEADBEEF); #1;
    chk("t3_c1_jt_grant", 64'(ram_addr), 64'(8'h00));
    chk("t3_c1_wait", 64'(av_waitrequest), 64'(1));
    tick();                                              // cycle 2, JT_RD
    take_na = 1; #1;
    chk("t3_c2_wait", 64'(av_waitrequest), 64'(1));
    tick(); take_na = 0; #1;                             // cycle 3, tie -> AV
    chk("t3_c3_av_grant", 64'(ram_addr), 64'(8'h10));
    chk("t3_c3_wait", 64'(av_waitrequest), 64'(1));
    chk("t3_c3_mondreg", 64'(MonDReg), 64'(32'h1000_0000));
    chk("t3_c3_overrun", 64'(jtag_overrun), 64'(0));
    tick(); #1;                                          // cycle 4, AV_RD
    chk("t3_c4_wait", 64'(av_waitrequest), 64'(0));
    tick(); av_read = 0; #1;                             // cycle 5, JT grant
    chk("t3_c5_jt_addr", 64'(ram_addr), 64'(8'h01));
    chk("t3_c5_wait", 64'(av_waitrequest), 64'(1));
    tick(); tick();
    chk("t3_mondreg2", 64'(MonDReg), 64'(32'h1000_0001));
    chk("t3_monaddr2", 64'(mon_addr), 64'(8'h02));

    // Pointer wrap and overrun on a strobe while busy
    jdo = jdo_addr(8'hFF, 1'b1); take_a = 1; tick(); take_a = 0;
    take_na = 1; tick(); take_na = 0;
    chk("t4_overrun_set", 64'(jtag_overrun), 64'(1));
    tick();
    chk("t4_wrap", 64'(mon_addr), 64'(8'h00));
    chk("t4_mondreg", 64'(MonDReg), 64'(32'h1000_00FF));
    chk("t4_ready", 64'(monitor_ready), 64'(1));
    tick();
    chk("t4_overrun_sticky", 64'(jtag_overrun), 64'(1));

    // Reset during a granted JTAG write: no RAM write, op discarded
    jdo = jdo_wr(32'h55AA55AA); take_b = 1; tick(); take_b = 0;
    reset = 1; #1;
    chk("t5_no_wren", 64'(ram_wren), 64'(0));
    tick(); reset = 0;
    chk("t5_ready", 64'(monitor_ready), 64'(1));
    chk("t5_overrun_clr", 64'(jtag_overrun), 64'(0));
    tick();

    // Reset during JT_RD
    take_na = 1; tick(); take_na = 0;
    tick();
    reset = 1; #1;
    chk("t5_jtrd_wren", 64'(ram_wren), 64'(0));
    tick(); reset = 0;
    chk("t5_jtrd_ready", 64'(monitor_ready), 64'(1));
    chk("t5_jtrd_mondreg", 64'(MonDReg), 64'(0));
    chk("t5_jtrd_monaddr", 64'(mon_addr), 64'(0));
    chk("t5_jtrd_wait", 64'(av_waitrequest), 64'(1));

    // Simultaneous strobes: address load wins, write dropped, overrun set
    jdo = jdo_addr(8'h30, 1'b0); take_a = 1; take_b = 1; tick(); take_a = 0; take_b = 0;
    chk("t6_monaddr", 64'(mon_addr), 64'(8'h30));
    chk("t6_overrun", 64'(jtag_overrun), 64'(1));
    chk("t6_ready", 64'(monitor_ready), 64'(1));
    tick();

    // Writes at and below the protection boundary
`ifdef NIOS_DBG_OCIMEM_WRPROT_EN
    av_wr(8'hC0, 32'h0000_0001, 4'hF, 1'b0);
    chk("t7_wp_err", 64'(av_wp_err), 64'(1));
    av_wr(8'hBF, 32'hCAFEF00D, 4'hF, 1'b1);
    av_rd(8'hC0, 32'h1000_00C0);
`else
    av_wr(8'hC0, 32'h0000_0001, 4'hF, 1'b1);
    av_wr(8'hBF, 32'hCAFEF00D, 4'hF, 1'b1);
    av_rd(8'hC0, 32'h0000_0001);
`endif
    av_rd(8'hBF, 32'hCAFEF00D);

    tick(); tick();
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
